branch_predictor_gshare: RTL and testbench

Parametrised two-level branch predictor with an integrated branch target buffer (BTB), serving the IF stage with registered taken/not-taken predictions and target PCs, trained by EX with resolved branch outcomes. It generalises the single-table predictor:
- configurable pattern-table depth, history length and BTB depth;
- a bimodal/gshare mode switch;
- a self-initialising table sweep after reset.

---
 rtl/branch_predictor_gshare_if.sv | 30 +++
 rtl/branch_predictor_gshare.sv | 141 ++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_if.sv
// Lookup / training bus between the IF/EX pipeline (master) and the gshare predictor (slave).
interface branch_predictor_gshare_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 6
);
    logic                   get_predict;
    logic [ADDR_WIDTH-1:0]  now_pc;
    logic                   pred_valid;
    logic                   jump_predict;
    logic [ADDR_WIDTH-1:0]  predict_pc;
    logic [INDEX_WIDTH-1:0] pred_index;
    logic                   update_predict;
    logic                   jump;
    logic [ADDR_WIDTH-1:0]  last_branch_pc;
    logic [ADDR_WIDTH-1:0]  last_branch_target;
    logic [INDEX_WIDTH-1:0] last_index;
    logic                   init_done;

    modport master (
        output get_predict, now_pc, update_predict, jump,
               last_branch_pc, last_branch_target, last_index,
        input  pred_valid, jump_predict, predict_pc, pred_index, init_done
    );

    modport slave (
        input  get_predict, now_pc, update_predict, jump,
               last_branch_pc, last_branch_target, last_index,
        output pred_valid, jump_predict, predict_pc, pred_index, init_done
    );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Two-level (bimodal/gshare) branch predictor with a direct-mapped BTB and a
// post-reset sweep that initialises both tables before predictions go live.
module branch_predictor_gshare #(
    parameter int ADDR_WIDTH      = 32,
    parameter int INDEX_WIDTH     = 6,
    parameter int GHR_WIDTH       = 4,
    parameter int BTB_INDEX_WIDTH = 4,
    parameter bit MODE            = 1'b1
) (
    input  logic clk,
    input  logic rst,
    branch_predictor_gshare_if.slave bp_io
);
    localparam int SWEEP_W = (INDEX_WIDTH > BTB_INDEX_WIDTH) ? INDEX_WIDTH : BTB_INDEX_WIDTH;
    localparam int TAG_W   = ADDR_WIDTH - BTB_INDEX_WIDTH - 2;
    localparam int PHT_N   = 1 << INDEX_WIDTH;
    localparam int BTB_N   = 1 << BTB_INDEX_WIDTH;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                 state_q, state_d;
    logic [SWEEP_W-1:0]     ptr_q, ptr_d;
    logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;

    logic [1:0]             pht_q     [PHT_N];
    logic                   btb_vld_q [BTB_N];
    logic [TAG_W-1:0]       btb_tag_q [BTB_N];
    logic [ADDR_WIDTH-1:0]  btb_tgt_q [BTB_N];

    logic                   pred_valid_q;
    logic                   jump_predict_q;
    logic [ADDR_WIDTH-1:0]  predict_pc_q;
    logic [INDEX_WIDTH-1:0] pred_index_q;

    logic sweep_en, upd_en, live;

    function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'd1;
        else       return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_INIT;
        else     state_q <= state_d;
    end

    // FSM: next state -- leave INIT once the last sweep slot is written
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (ptr_q == '1) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sweep_en = 1'b0;
        upd_en   = 1'b0;
        live     = 1'b0;
        case (state_q)
            S_INIT:  sweep_en = 1'b1;
            S_RUN: begin
                live   = 1'b1;
                upd_en = bp_io.update_predict;
            end
            default: ;
        endcase
    end

    assign ptr_d = ptr_q + 1'b1;
    assign ghr_d = GHR_WIDTH'({ghr_q, bp_io.jump});

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            ghr_q <= '0;
        end else begin
            if (sweep_en) ptr_q <= ptr_d;
            if (upd_en)   ghr_q <= ghr_d;
        end
    end

    // Table writes: sweep slots are masked down to each table's own depth
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (sweep_en) begin
                pht_q[ptr_q[INDEX_WIDTH-1:0]]         <= 2'b01;
                btb_vld_q[ptr_q[BTB_INDEX_WIDTH-1:0]] <= 1'b0;
            end else if (upd_en) begin
                pht_q[bp_io.last_index] <= sat_cnt(pht_q[bp_io.last_index], bp_io.jump);
                if (bp_io.jump) begin
                    btb_vld_q[bp_io.last_branch_pc[BTB_INDEX_WIDTH+1:2]] <= 1'b1;
                    btb_tag_q[bp_io.last_branch_pc[BTB_INDEX_WIDTH+1:2]] <=
                        bp_io.last_branch_pc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2];
                    btb_tgt_q[bp_io.last_branch_pc[BTB_INDEX_WIDTH+1:2]] <= bp_io.last_branch_target;
                end
            end
        end
    end

    logic [INDEX_WIDTH-1:0]     pc_idx, lk_idx;
    logic [BTB_INDEX_WIDTH-1:0] btb_idx;
    logic                       btb_hit, lk_taken;
    logic [ADDR_WIDTH-1:0]      pc_inc;
    logic                       unused_lbpc;

    assign pc_idx   = bp_io.now_pc[INDEX_WIDTH+1:2];
    assign lk_idx   = MODE ? (pc_idx ^ INDEX_WIDTH'(ghr_q)) : pc_idx;
    assign btb_idx  = bp_io.now_pc[BTB_INDEX_WIDTH+1:2];
    assign btb_hit  = btb_vld_q[btb_idx] &&
                      (btb_tag_q[btb_idx] == bp_io.now_pc[ADDR_WIDTH-1:BTB_INDEX_WIDTH+2]);
    // Tables hold garbage until the sweep finishes, so INIT always falls through
    assign lk_taken = live && pht_q[lk_idx][1] && btb_hit;
    assign pc_inc   = bp_io.now_pc + ADDR_WIDTH'(4);
    assign unused_lbpc = ^bp_io.last_branch_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid_q   <= 1'b0;
            jump_predict_q <= 1'b0;
            predict_pc_q   <= '0;
            pred_index_q   <= '0;
        end else begin
            pred_valid_q <= bp_io.get_predict;
            if (bp_io.get_predict) begin
                jump_predict_q <= lk_taken;
                predict_pc_q   <= lk_taken ? btb_tgt_q[btb_idx] : pc_inc;
                pred_index_q   <= lk_idx;
            end
        end
    end

    assign bp_io.pred_valid   = pred_valid_q;
    assign bp_io.jump_predict = jump_predict_q;
    assign bp_io.predict_pc   = predict_pc_q;
    assign bp_io.pred_index   = pred_index_q;
    assign bp_io.init_done    = live;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench: one bimodal and one gshare predictor driven from a shared vector table.
module tb_branch_predictor_gshare;
    localparam int AW = 32;
    localparam int IW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predictor_gshare_if #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) bus0 ();
    branch_predictor_gshare_if #(.ADDR_WIDTH(AW), .INDEX_WIDTH(IW)) bus1 ();

    branch_predictor_gshare #(.MODE(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bp_io(bus0));
    branch_predictor_gshare #(.MODE(1'b1)) u_dut1 (.clk(clk), .rst(rst), .bp_io(bus1));

    typedef struct {
        bit          sel;
        bit          get;
        logic [31:0] pc;
        bit          upd;
        bit          jump;
        logic [31:0] lpc;
        logic [31:0] ltgt;
        logic [5:0]  lidx;
        bit          ej;
        logic [31:0] epc;
        logic [5:0]  eidx;
    } vec_t;

    vec_t        vecs[$];
    vec_t        post[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_pc [2];

    function automatic vec_t V(bit sel, bit get, logic [31:0] pc, bit upd, bit j,
                               logic [31:0] lpc, logic [31:0] ltgt, logic [5:0] lidx,
                               bit ej, logic [31:0] epc, logic [5:0] eidx);
        vec_t v;
        v.sel = sel; v.get = get; v.pc = pc; v.upd = upd; v.jump = j;
        v.lpc = lpc; v.ltgt = ltgt; v.lidx = lidx; v.ej = ej; v.epc = epc; v.eidx = eidx;
        return v;
    endfunction

    function automatic vec_t L(bit sel, logic [31:0] pc, bit ej, logic [31:0] epc, logic [5:0] eidx);
        return V(sel, 1'b1, pc, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0, ej, epc, eidx);
    endfunction

    function automatic vec_t U(bit sel, logic [31:0] lpc, logic [31:0] ltgt, bit j, logic [5:0] lidx);
        return V(sel, 1'b0, 32'h0, 1'b1, j, lpc, ltgt, lidx, 1'b0, 32'h0, 6'd0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drv(input bit sel, input bit get, input logic [31:0] pc, input bit upd,
                       input bit j, input logic [31:0] lpc, input logic [31:0] ltgt,
                       input logic [5:0] lidx);
        if (sel) begin
            bus1.get_predict = get; bus1.now_pc = pc; bus1.update_predict = upd; bus1.jump = j;
            bus1.last_branch_pc = lpc; bus1.last_branch_target = ltgt; bus1.last_index = lidx;
        end else begin
            bus0.get_predict = get; bus0.now_pc = pc; bus0.update_predict = upd; bus0.jump = j;
            bus0.last_branch_pc = lpc; bus0.last_branch_target = ltgt; bus0.last_index = lidx;
        end
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0);
        drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0);
    endtask

    task automatic rd(input bit sel, output logic pv, output logic jp, output logic [31:0] pc,
                      output logic [5:0] idx, output logic done);
        if (sel) begin
            pv = bus1.pred_valid; jp = bus1.jump_predict; pc = bus1.predict_pc;
            idx = bus1.pred_index; done = bus1.init_done;
        end else begin
            pv = bus0.pred_valid; jp = bus0.jump_predict; pc = bus0.predict_pc;
            idx = bus0.pred_index; done = bus0.init_done;
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        logic pv, jp, dn;
        logic [31:0] pc;
        logic [5:0] idx;
        drv(v.sel, v.get, v.pc, v.upd, v.jump, v.lpc, v.ltgt, v.lidx);
        @(posedge clk); #1;
        rd(v.sel, pv, jp, pc, idx, dn);
        if (v.get) begin
            check({tag, ".pred_valid"}, 32'(pv), 32'd1);
            check({tag, ".jump_predict"}, 32'(jp), 32'(v.ej));
            check({tag, ".predict_pc"}, pc, v.epc);
            check({tag, ".pred_index"}, 32'(idx), 32'(v.eidx));
            last_pc[v.sel] = v.epc;
        end else begin
            check({tag, ".pred_valid_idle"}, 32'(pv), 32'd0);
            check({tag, ".predict_pc_hold"}, pc, last_pc[v.sel]);
        end
        idle();
    endtask

    // Counts 64 sweep edges; optionally injects an INIT lookup or an (ignored) update.
    task automatic sweep(input string tag, input int look_at, input int upd_at);
        logic pv, jp, dn0, dn1;
        logic [31:0] pc;
        logic [5:0] idx;
        for (int e = 1; e <= 64; e++) begin
            if (e == look_at) begin
                drv(1'b0, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0);
                drv(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 6'd0);
            end
            if (e == upd_at) drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h80, 6'd0);
            @(posedge clk); #1;
            if (e == look_at) begin
                for (int s = 0; s < 2; s++) begin
                    rd(s[0], pv, jp, pc, idx, dn0);
                    check($sformatf("%s.init_look%0d.valid", tag, s), 32'(pv), 32'd1);
                    check($sformatf("%s.init_look%0d.jump", tag, s), 32'(jp), 32'd0);
                    check($sformatf("%s.init_look%0d.pc", tag, s), pc, 32'h104);
                    last_pc[s] = 32'h104;
                end
            end
            idle();
            dn0 = bus0.init_done;
            dn1 = bus1.init_done;
            check($sformatf("%s.init_done0.e%0d", tag, e), 32'(dn0), (e == 64) ? 32'd1 : 32'd0);
            check($sformatf("%s.init_done1.e%0d", tag, e), 32'(dn1), (e == 64) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        logic pv, jp, dn;
        logic [31:0] pc;
        logic [5:0] idx;

        // MODE 0 (sel 0): training, saturation, wrap, tag miss, same-cycle lookup/update
        vecs.push_back(U(0, 32'h100, 32'h80, 1, 6'd0));          // 01 -> 10
        vecs.push_back(L(0, 32'h100, 1, 32'h80, 6'd0));
        vecs.push_back(U(0, 32'h100, 32'h80, 1, 6'd0));          // 11
        vecs.push_back(U(0, 32'h100, 32'h80, 1, 6'd0));          // 11
        vecs.push_back(U(0, 32'h100, 32'h80, 1, 6'd0));          // 11
        vecs.push_back(U(0, 32'h100, 32'h80, 0, 6'd0));          // 10
        vecs.push_back(L(0, 32'h100, 1, 32'h80, 6'd0));
        vecs.push_back(U(0, 32'h100, 32'h80, 0, 6'd0));          // 01
        vecs.push_back(U(0, 32'h100, 32'h80, 0, 6'd0));          // 00
        vecs.push_back(L(0, 32'h100, 0, 32'h104, 6'd0));
        vecs.push_back(U(0, 32'h100, 32'h80, 0, 6'd0));          // stays 00
        vecs.push_back(U(0, 32'h100, 32'h80, 1, 6'd0));          // 01
        vecs.push_back(L(0, 32'h100, 0, 32'h104, 6'd0));
        vecs.push_back(L(0, 32'hFFFF_FFFC, 0, 32'h0, 6'h3F));
        vecs.push_back(U(0, 32'h114, 32'h200, 1, 6'd5));
        vecs.push_back(L(0, 32'h114, 1, 32'h200, 6'd5));
        vecs.push_back(L(0, 32'h514, 0, 32'h518, 6'd5));         // PHT taken, BTB tag miss
        vecs.push_back(V(0, 1, 32'h100, 1, 1, 32'h100, 32'h80, 6'd0, 0, 32'h104, 6'd0));
        vecs.push_back(L(0, 32'h100, 1, 32'h80, 6'd0));
        // MODE 1 (sel 1): history-hashed index
        vecs.push_back(L(1, 32'h100, 0, 32'h104, 6'd0));
        vecs.push_back(U(1, 32'h100, 32'h80, 1, 6'd0));          // GHR 0001
        vecs.push_back(L(1, 32'h100, 0, 32'h104, 6'd1));
        vecs.push_back(U(1, 32'h124, 32'h0, 0, 6'd9));           // GHR 0010
        vecs.push_back(L(1, 32'h100, 0, 32'h104, 6'd2));
        vecs.push_back(U(1, 32'h100, 32'h80, 1, 6'd5));          // PHT5 10, GHR 0101
        vecs.push_back(L(1, 32'h100, 1, 32'h80, 6'd5));
        vecs.push_back(L(1, 32'h108, 0, 32'h10C, 6'd7));

        post.push_back(L(0, 32'h100, 0, 32'h104, 6'd0));
        post.push_back(L(0, 32'h114, 0, 32'h118, 6'd5));
        post.push_back(L(1, 32'h100, 0, 32'h104, 6'd0));

        last_pc[0] = 32'h0;
        last_pc[1] = 32'h0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            rd(s[0], pv, jp, pc, idx, dn);
            check($sformatf("reset%0d.pred_valid", s), 32'(pv), 32'd0);
            check($sformatf("reset%0d.jump_predict", s), 32'(jp), 32'd0);
            check($sformatf("reset%0d.predict_pc", s), pc, 32'd0);
            check($sformatf("reset%0d.pred_index", s), 32'(idx), 32'd0);
            check($sformatf("reset%0d.init_done", s), 32'(dn), 32'd0);
        end
        rst = 1'b0;
        sweep("sweep1", 10, 0);

        foreach (vecs[i]) apply($sformatf("v%0d", i), vecs[i]);

        // Reset mid-RUN with a same-cycle update, then reset again at sweep pointer 30
        rst = 1'b1;
        drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h80, 6'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();
        for (int s = 0; s < 2; s++) begin
            rd(s[0], pv, jp, pc, idx, dn);
            check($sformatf("rst_run%0d.pred_valid", s), 32'(pv), 32'd0);
            check($sformatf("rst_run%0d.predict_pc", s), pc, 32'd0);
            check($sformatf("rst_run%0d.init_done", s), 32'(dn), 32'd0);
            last_pc[s] = 32'h0;
        end
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep("sweep2", 0, 40);

        foreach (post[i]) apply($sformatf("post%0d", i), post[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
